fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction-fetch sequencer for the MIPS core. Owns the program counter, drives the instruction-memory request/acknowledge handshake, and buffers one fetched instruction for decode. It applies the 2-bit next-PC select produced by the jump/branch controller when a control-flow decision resolves. Redirects that arrive while a fetch is in flight are handled by draining and discarding the stale response, then flushing downstream.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- redirect_valid  in  1  control-flow decision resolved this cycle
- pc_sel  in  2  {out1,out0} from jump/branch controller: 00 sequential, 01 branch, 11 jump, 10 register address
- branch_target  in  32  branch destination
- jump_target  in  32  jump destination
- reg_target  in  32  register-indirect destination
- imem_req  out  1  fetch request, registered
- imem_addr  out  32  fetch address, registered, word aligned
- imem_ack  in  1  memory response valid; sampled only while imem_req=1
- imem_rdata  in  32  instruction word, valid with imem_ack
- inst_valid  out  1  instruction buffer occupied
- inst_ready  in  1  decode accepts the buffer this cycle
- inst_out  out  32  buffered instruction
- inst_pc  out  32  address of inst_out
- flush  out  1  one-cycle pulse: squash younger instructions in decode/execute

## Operation
- Registers: pc, state, the instruction buffer (inst_valid/inst_out/inst_pc), imem_req/imem_addr, and flush.
- A redirect is taken when redirect_valid=1 and pc_sel≠00. Target is branch_target (01), jump_target (11) or reg_target (10). redirect_valid with pc_sel=00 is a no-op.
- State IDLE (reset state): imem_req=0. The next cycle goes to FETCH.
- State FETCH:
  - When the buffer is empty and imem_req=0, register imem_req=1 and imem_addr=pc.
  - imem_req/imem_addr then hold, unchanged, until imem_ack.
  - On imem_ack with no redirect: inst_out←imem_rdata, inst_pc←imem_addr, inst_valid←1, pc←pc+4 (mod 2^32, wraps to 0), imem_req←0. Stay in FETCH.
- The buffer clears (inst_valid←0) on inst_valid & inst_ready.
- No request is issued while inst_valid=1.
- Redirect is taken in any state:
  - pc←target, inst_valid←0, flush←1 for exactly one cycle.
  - Redirect has priority over an ack in the same cycle; that response is discarded.
  - If imem_req=1 and imem_ack=0, go to DRAIN.
  - Otherwise go to FETCH with imem_req←0.
- State DRAIN:
  - imem_req and the old imem_addr are held until imem_ack. Handshake rule: a request is never withdrawn.
  - On ack the data is discarded, imem_req←0, and the state goes to FETCH.
  - A further redirect in DRAIN overwrites pc with the newest target, pulses flush again, and stays in DRAIN.
- Target bits [1:0] are forced to 00 when loaded into pc.
- Reset mid-fetch abandons the handshake: imem_req←0 immediately. Memory must tolerate a dropped request on reset.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst_out=0, inst_pc=0, flush=0, pc=RESET_PC, state=IDLE.
- First imem_req is at the 2nd rising edge after rst_n rises: IDLE→FETCH, then the request registers.
- Zero-wait memory (ack in the first req cycle): inst_valid rises 1 cycle after ack.
- Best-case throughput is one instruction per 2 cycles with inst_ready tied high.
- flush is asserted in the cycle after the redirect edge. The first request to the target issues 1 cycle after entering FETCH.
- Redirect to first new-target request, no outstanding fetch: 1 cycle.
- Redirect to first new-target request, outstanding fetch: (cycles to stale ack) + 1.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package cpu_pkg holds:
  - the pc_sel encodings PCSEL_SEQ=2'b00, PCSEL_BR=2'b01, PCSEL_REG=2'b10, PCSEL_JMP=2'b11 (shared with the jump/branch controller);
  - the state enum {IDLE, FETCH, DRAIN};
  - the word constant 32'd4.
- One sub-module, next_pc_mux: combinational target select plus alignment. The FSM and buffer stay in fetch_sequencer.

## Test plan
- Reset, RESET_PC=32'h0000_0040, zero-wait memory, inst_ready=1 → requests to 0x40, 0x44, 0x48 on every other cycle; inst_pc matches each.
- Memory with 3-cycle ack latency, inst_ready=0 for 5 cycles after the first ack → imem_addr stable across the wait, and no second request until the buffer is consumed.
- Redirect pc_sel=01, branch_target=32'h0000_1002, while idle in FETCH → flush pulses 1 cycle, and the next request is to 0x1000.
- Redirect pc_sel=11, jump_target=0x2000, 1 cycle into a 4-cycle fetch of 0x44 → imem_addr held at 0x44 until ack, data discarded with inst_valid=0, next request to 0x2000.
- Redirect and imem_ack in the same cycle, pc_sel=10, reg_target=0x3000 → no instruction delivered, next request to 0x3000.
- pc=32'hFFFF_FFFC, sequential fetch → next request to 0x0000_0000. Separately, rst_n=0 during an outstanding request → all outputs return to their reset values on the next edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: next-PC select encodings, fetch FSM states and the
// instruction word size.
package cpu_pkg;

  localparam logic [1:0] PCSEL_SEQ = 2'b00;
  localparam logic [1:0] PCSEL_BR  = 2'b01;
  localparam logic [1:0] PCSEL_REG = 2'b10;
  localparam logic [1:0] PCSEL_JMP = 2'b11;

  localparam logic [31:0] WORD = 32'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_mux.sv
// Next-PC select: sequential increment or one of three control-flow targets,
// always delivered word aligned.
module next_pc_mux
  import cpu_pkg::*;
(
  input  logic [1:0]  i_sel,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_branch,
  input  logic [31:0] i_jump,
  input  logic [31:0] i_reg,
  output logic [31:0] o_next_pc
);

  logic [31:0] w_raw;

  always_comb begin
    w_raw = i_pc + WORD;
    case (i_sel)
      PCSEL_BR:  w_raw = i_branch;
      PCSEL_JMP: w_raw = i_jump;
      PCSEL_REG: w_raw = i_reg;
      default:   w_raw = i_pc + WORD;
    endcase
  end

  assign o_next_pc = word_align(w_raw);

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, runs the imem req/ack handshake,
// buffers one instruction for decode and absorbs redirects mid-fetch.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [1:0]  pc_sel,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic [31:0] reg_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        flush
);

  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic         r_req;
  logic [31:0]  r_addr;
  logic         r_inst_valid;
  logic [31:0]  r_inst_out;
  logic [31:0]  r_inst_pc;
  logic         r_flush;

  logic         w_take;
  logic [1:0]   w_sel;
  logic [31:0]  w_next_pc;
  logic         w_buf_free;

  assign w_take = redirect_valid && (pc_sel != PCSEL_SEQ);
  assign w_sel  = w_take ? pc_sel : PCSEL_SEQ;
  // A buffer being consumed this edge counts as free, giving 2-cycle throughput.
  assign w_buf_free = !r_inst_valid || inst_ready;

  next_pc_mux u_next_pc (
    .i_sel     (w_sel),
    .i_pc      (r_pc),
    .i_branch  (branch_target),
    .i_jump    (jump_target),
    .i_reg     (reg_target),
    .o_next_pc (w_next_pc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_pc         <= RESET_PC;
      r_req        <= 1'b0;
      r_addr       <= RESET_PC;
      r_inst_valid <= 1'b0;
      r_inst_out   <= 32'h0;
      r_inst_pc    <= 32'h0;
      r_flush      <= 1'b0;
    end else begin
      r_flush <= 1'b0;
      if (r_inst_valid && inst_ready)
        r_inst_valid <= 1'b0;

      if (w_take) begin
        r_pc         <= w_next_pc;
        r_inst_valid <= 1'b0;
        r_flush      <= 1'b1;
        // An unacknowledged request must stay up; its response is dropped in DRAIN.
        if (r_req && !imem_ack) begin
          r_state <= DRAIN;
        end else begin
          r_state <= FETCH;
          r_req   <= 1'b0;
        end
      end else begin
        case (r_state)
          IDLE: r_state <= FETCH;
          FETCH: begin
            if (r_req) begin
              if (imem_ack) begin
                r_inst_out   <= imem_rdata;
                r_inst_pc    <= r_addr;
                r_inst_valid <= 1'b1;
                r_pc         <= w_next_pc;
                r_req        <= 1'b0;
              end
            end else if (w_buf_free) begin
              r_req  <= 1'b1;
              r_addr <= r_pc;
            end
          end
          DRAIN: begin
            if (imem_ack) begin
              r_req   <= 1'b0;
              r_state <= FETCH;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign imem_req   = r_req;
  assign imem_addr  = r_addr;
  assign inst_valid = r_inst_valid;
  assign inst_out   = r_inst_out;
  assign inst_pc    = r_inst_pc;
  assign flush      = r_flush;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: latency-programmable memory responder, a
// behavioural reference checked every cycle, and directed scenarios.
module tb_fetch_sequencer;

  localparam logic [31:0] RPC = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [1:0]  pc_sel = 2'b00;
  logic [31:0] branch_target = 32'h0;
  logic [31:0] jump_target = 32'h0;
  logic [31:0] reg_target = 32'h0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        inst_ready = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        flush;

  fetch_sequencer #(.RESET_PC(RPC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .pc_sel         (pc_sel),
    .branch_target  (branch_target),
    .jump_target    (jump_target),
    .reg_target     (reg_target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_out       (inst_out),
    .inst_pc        (inst_pc),
    .flush          (flush)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rel_cyc = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // memory: ack in the lat-th cycle of a request
  int lat = 1;
  int cnt = 0;
  always @(negedge clk) begin
    if (imem_req === 1'b1) cnt++;
    else cnt = 0;
    imem_ack   = (imem_req === 1'b1) && (cnt >= lat);
    imem_rdata = imem_ack ? memf(imem_addr) : 32'h0;
  end

  // reference: outstanding request, stale-response flag, one-entry buffer
  logic        m_req, m_valid, m_flush, m_run, m_stale;
  logic [31:0] m_addr, m_out, m_ipc, m_pc, m_tgt;
  logic        m_take, m_free;
  bit          m_ok = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_req = 0; m_addr = RPC; m_valid = 0; m_out = 0; m_ipc = 0;
      m_flush = 0; m_pc = RPC; m_run = 0; m_stale = 0; m_ok = 1'b1;
    end else begin
      m_take = redirect_valid && (pc_sel != 2'b00);
      m_tgt  = (pc_sel == 2'b01) ? branch_target :
               (pc_sel == 2'b11) ? jump_target : reg_target;
      m_tgt  = m_tgt & 32'hFFFF_FFFC;
      m_free = !m_valid || inst_ready;
      m_flush = m_take;
      if (m_valid && inst_ready) m_valid = 0;
      if (m_take) begin
        m_pc = m_tgt; m_valid = 0; m_run = 1;
        if (m_req && !imem_ack) m_stale = 1;
        else begin m_req = 0; m_stale = 0; end
      end else if (!m_run) begin
        m_run = 1;
      end else if (m_req) begin
        if (imem_ack) begin
          m_req = 0;
          if (!m_stale) begin
            m_valid = 1; m_out = imem_rdata; m_ipc = m_addr; m_pc = m_pc + 32'd4;
          end
          m_stale = 0;
        end
      end else if (m_free) begin
        m_req = 1; m_addr = m_pc;
      end
    end
  end

  int          req_addr[$];
  int          req_cyc[$];
  int          inst_pcs[$];
  int          inst_outs[$];
  int          inst_cyc[$];
  int          flush_cyc[$];
  logic        prev_req = 1'b0;
  logic        prev_valid = 1'b0;

  always @(negedge clk) begin
    if (m_ok) begin
      chk("imem_req",   {31'h0, imem_req},   {31'h0, m_req});
      chk("imem_addr",  imem_addr,           m_addr);
      chk("inst_valid", {31'h0, inst_valid}, {31'h0, m_valid});
      chk("inst_out",   inst_out,            m_out);
      chk("inst_pc",    inst_pc,             m_ipc);
      chk("flush",      {31'h0, flush},      {31'h0, m_flush});
      if (imem_req && !prev_req) begin req_addr.push_back(imem_addr); req_cyc.push_back(cyc); end
      if (inst_valid && !prev_valid) begin
        inst_pcs.push_back(inst_pc); inst_outs.push_back(inst_out); inst_cyc.push_back(cyc);
      end
      if (flush) flush_cyc.push_back(cyc);
      prev_req   = imem_req;
      prev_valid = inst_valid;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); #2; end
  endtask

  task automatic clear_logs();
    req_addr.delete(); req_cyc.delete(); inst_pcs.delete();
    inst_outs.delete(); inst_cyc.delete(); flush_cyc.delete();
  endtask

  task automatic do_reset(input int l, input logic rdy);
    rst_n = 1'b0; redirect_valid = 1'b0; pc_sel = 2'b00;
    lat = l; inst_ready = rdy;
    tick(2);
    clear_logs();
    rst_n = 1'b1;
    rel_cyc = cyc;
  endtask

  task automatic redirect(input logic [1:0] s, input logic [31:0] t);
    branch_target = 32'h0000_BAD0; jump_target = 32'h000D_EAD0; reg_target = 32'h000B_EEF0;
    case (s)
      2'b01:   branch_target = t;
      2'b11:   jump_target   = t;
      default: reg_target    = t;
    endcase
    pc_sel = s; redirect_valid = 1'b1;
    tick(1);
    redirect_valid = 1'b0; pc_sel = 2'b00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // zero-wait memory, decode always ready
    do_reset(1, 1'b1);
    tick(10);
    chk("t1_first_req_lat", req_cyc[0] - rel_cyc, 2);
    chk("t1_req0", req_addr[0], 32'h40);
    chk("t1_req1", req_addr[1], 32'h44);
    chk("t1_req2", req_addr[2], 32'h48);
    chk("t1_gap01", req_cyc[1] - req_cyc[0], 2);
    chk("t1_gap12", req_cyc[2] - req_cyc[1], 2);
    chk("t1_ipc0", inst_pcs[0], 32'h40);
    chk("t1_ipc1", inst_pcs[1], 32'h44);
    chk("t1_ipc2", inst_pcs[2], 32'h48);
    chk("t1_iout0", inst_outs[0], memf(32'h40));
    chk("t1_ack_to_valid", inst_cyc[0] - req_cyc[0], 1);

    // 3-cycle memory, decode stalled for 5 cycles after the first delivery
    do_reset(3, 1'b0);
    for (int i = 0; i < 30 && !inst_valid; i++) tick(1);
    chk("t2_got_inst", {31'h0, inst_valid}, 32'h1);
    tick(5);
    chk("t2_no_second_req", req_addr.size(), 1);
    chk("t2_held_pc", inst_pc, 32'h40);
    chk("t2_req_to_valid", inst_cyc[0] - req_cyc[0], 3);
    inst_ready = 1'b1;
    for (int i = 0; i < 30 && req_addr.size() < 2; i++) tick(1);
    chk("t2_req1", req_addr[1], 32'h44);

    // branch redirect while idle with a full buffer; a pc_sel=00 redirect is ignored
    do_reset(1, 1'b0);
    for (int i = 0; i < 30 && !inst_valid; i++) tick(1);
    tick(2);
    clear_logs();
    pc_sel = 2'b00; redirect_valid = 1'b1; branch_target = 32'h0000_5550;
    tick(1);
    redirect_valid = 1'b0;
    chk("t3_seq_noop_flush", {31'h0, flush}, 32'h0);
    chk("t3_seq_noop_valid", {31'h0, inst_valid}, 32'h1);
    redirect(2'b01, 32'h0000_1002);
    chk("t3_flush_hi", {31'h0, flush}, 32'h1);
    chk("t3_buf_dropped", {31'h0, inst_valid}, 32'h0);
    tick(1);
    chk("t3_flush_lo", {31'h0, flush}, 32'h0);
    tick(3);
    chk("t3_nflush", flush_cyc.size(), 1);
    chk("t3_req_target", req_addr[0], 32'h1000);
    chk("t3_redirect_to_req", req_cyc[0] - flush_cyc[0], 1);
    chk("t3_ipc", inst_pc, 32'h1000);

    // jump one cycle into a 4-cycle fetch of 0x44
    do_reset(4, 1'b1);
    for (int i = 0; i < 40 && !(imem_req && imem_addr == 32'h44); i++) tick(1);
    chk("t4_fetch44", imem_addr, 32'h44);
    tick(1);
    clear_logs();
    redirect(2'b11, 32'h0000_2000);
    chk("t4_hold_req", {31'h0, imem_req}, 32'h1);
    chk("t4_hold_addr", imem_addr, 32'h44);
    tick(6);
    chk("t4_req_target", req_addr[0], 32'h2000);
    for (int i = 0; i < 30 && inst_pcs.size() < 1; i++) tick(1);
    chk("t4_first_inst", inst_pcs[0], 32'h2000);
    chk("t4_nflush", flush_cyc.size(), 1);

    // register redirect in the same cycle as an ack
    do_reset(2, 1'b1);
    for (int i = 0; i < 30 && !imem_ack; i++) tick(1);
    chk("t5_ack_seen", {31'h0, imem_ack}, 32'h1);
    clear_logs();
    redirect(2'b10, 32'h0000_3000);
    chk("t5_dropped", {31'h0, inst_valid}, 32'h0);
    for (int i = 0; i < 30 && inst_pcs.size() < 1; i++) tick(1);
    chk("t5_req_target", req_addr[0], 32'h3000);
    chk("t5_first_inst", inst_pcs[0], 32'h3000);

    // PC wrap past the top of the address space, unaligned target
    do_reset(1, 1'b1);
    tick(4);
    clear_logs();
    redirect(2'b11, 32'hFFFF_FFFE);
    tick(8);
    chk("t6_req_top", req_addr[0], 32'hFFFF_FFFC);
    chk("t6_req_wrap", req_addr[1], 32'h0);
    chk("t6_ipc_top", inst_pcs[0], 32'hFFFF_FFFC);
    chk("t6_ipc_wrap", inst_pcs[1], 32'h0);

    // reset during an outstanding request
    do_reset(5, 1'b1);
    for (int i = 0; i < 30 && !imem_req; i++) tick(1);
    tick(1);
    chk("t7_pending", {31'h0, imem_req}, 32'h1);
    rst_n = 1'b0;
    tick(1);
    chk("t7_req",   {31'h0, imem_req},   32'h0);
    chk("t7_addr",  imem_addr,           RPC);
    chk("t7_valid", {31'h0, inst_valid}, 32'h0);
    chk("t7_out",   inst_out,            32'h0);
    chk("t7_ipc",   inst_pc,             32'h0);
    chk("t7_flush", {31'h0, flush},      32'h0);
    rst_n = 1'b1;
    tick(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
